// File: rtl/clock_domain_import_fifo.sv
// Destination side of a two-wire valid/ack CDC: synchronizes the request, queues each word
// in a small FIFO and holds off ack while full. Optional: CLOCK_DOMAIN_IMPORT_DROP_EN.
module clock_domain_import_fifo #(
    parameter int SIZE        = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIZE-1:0]          handshake_data,
    input  logic                     handshake_valid,
    output logic                     handshake_ack,
    output logic [SIZE-1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic {IDLE, ACKED} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   vs;
    logic [SIZE-1:0]        mem [DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr, level_q;
    logic                   empty, full, push, pop;

    assign vs = vld_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], handshake_valid};
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_ready;

`ifdef CLOCK_DOMAIN_IMPORT_DROP_EN
    logic drop;

    always_comb begin
        state_n = state;
        push    = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE:  if (vs) begin
                       state_n = ACKED;
                       push    = !full;
                       drop    = full;
                   end
            ACKED: if (!vs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Sticky: once a word has been lost, only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end
`else
    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            // Full test uses pre-pop state: a same-cycle pop does not free a slot.
            IDLE:  if (vs && !full) begin
                       state_n = ACKED;
                       push    = 1'b1;
                   end
            ACKED: if (!vs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    assign handshake_ack = (state == ACKED);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= handshake_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
            case ({push, pop})
                2'b10:   level_q <= level_q + ONE;
                2'b01:   level_q <= level_q - ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign level     = level_q;

endmodule
